// File: rtl/forward_scoreboard_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package forward_scoreboard_pkg;

  // Widest register address an entry can carry; narrower addresses are zero-extended.
  localparam int AW_MAX = 8;

  // fwd_sel encoding: SEL_RF means "read the register file", k+1 means "entry k".
  localparam int SEL_RF = 0;

  // One tracked pipeline-register slot.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic              is_load;
    logic              is_store;
    logic [AW_MAX-1:0] rd;
    logic [AW_MAX-1:0] rt;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

  // Width of one fwd_sel field: enough to encode SEL_RF plus one code per entry.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// Priority match of one source operand against all tracked entries.
module fwd_match
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1,
  parameter int SW       = 2
) (
  input  entry_t [DEPTH-1:0] entries,
  input  logic               src_valid,
  input  logic [AW-1:0]      src_addr,
  output logic [SW-1:0]      sel,
  output logic               hazard
);

  logic [AW_MAX-1:0] addr_ext;
  logic              unused_fields;

  assign addr_ext = AW_MAX'(src_addr);

  // Scan oldest to youngest so the youngest (lowest index) matching writer wins.
  always_comb begin
    sel    = SW'(SEL_RF);
    hazard = 1'b0;
    if (src_valid && (addr_ext != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entries[k].valid && entries[k].we && (entries[k].rd == addr_ext)) begin
          sel    = SW'(k + 1);
          hazard = entries[k].is_load && (k < LOAD_LAT);
        end
      end
    end
  end

  // Store-related fields are not needed for operand matching.
  always_comb begin
    unused_fields = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      unused_fields = unused_fields ^ entries[k].is_store ^ (^entries[k].rt);
    end
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers, selects bypass sources,
// detects load-use hazards and counts stalled cycles.
// No handshakes here: advance is a plain enable; the instruction entering EX
// is held by the surrounding pipeline whenever stall is high.
module forward_scoreboard
  import forward_scoreboard_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int AW       = 5
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   advance,
  input  logic                                   flush,
  input  logic                                   issue_valid,
  input  logic                                   issue_we,
  input  logic                                   issue_is_load,
  input  logic                                   issue_is_store,
  input  logic [AW-1:0]                          issue_rd,
  input  logic [AW-1:0]                          issue_rt,
  input  logic [NUM_SRC-1:0]                     src_valid,
  input  logic [NUM_SRC*AW-1:0]                  src_addr,
  output logic [NUM_SRC*sel_width(DEPTH)-1:0]    fwd_sel,
  output logic                                   stall,
  output logic                                   forwardM,
  output logic [15:0]                            stall_count,
  input  logic                                   clear_stats
);

  localparam int SW = sel_width(DEPTH);

  entry_t [DEPTH-1:0] entries_q, entries_d;
  entry_t             issue_entry;
  logic [NUM_SRC-1:0] hazard;
  logic [15:0]        stall_count_q, stall_count_d;

  // Pack the incoming instruction into an entry record.
  always_comb begin
    issue_entry          = ENTRY_BUBBLE;
    issue_entry.valid    = issue_valid;
    issue_entry.we       = issue_we;
    issue_entry.is_load  = issue_is_load;
    issue_entry.is_store = issue_is_store;
    issue_entry.rd       = AW_MAX'(issue_rd);
    issue_entry.rt       = AW_MAX'(issue_rt);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_match
    fwd_match #(
      .DEPTH    (DEPTH),
      .AW       (AW),
      .LOAD_LAT (LOAD_LAT),
      .SW       (SW)
    ) u_fwd_match (
      .entries   (entries_q),
      .src_valid (src_valid[i]),
      .src_addr  (src_addr[i*AW +: AW]),
      .sel       (fwd_sel[i*SW +: SW]),
      .hazard    (hazard[i])
    );
  end

  // A hazard only stalls a real, unsquashed instruction.
  always_comb begin
    stall = (|hazard) && issue_valid && !flush;
  end

  // Store in MEM whose data register is being loaded by the instruction in WB.
  always_comb begin
    forwardM = entries_q[0].valid && entries_q[0].is_store &&
               entries_q[1].valid && entries_q[1].is_load && entries_q[1].we &&
               (entries_q[1].rd == entries_q[0].rt) && (entries_q[0].rt != '0);
  end

  // Shift on advance, inserting a bubble for stalled or flushed issues.
  always_comb begin
    entries_d = entries_q;
    if (advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = (stall || flush) ? ENTRY_BUBBLE : issue_entry;
    end else if (flush) begin
      entries_d[0].valid = 1'b0;
    end
  end

  // Saturating stall counter; clear takes priority over counting.
  always_comb begin
    stall_count_d = stall_count_q;
    if (clear_stats) begin
      stall_count_d = '0;
    end else if (stall && advance && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q     <= '0;
      stall_count_q <= '0;
    end else begin
      entries_q     <= entries_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, number of tracked pipeline-register entries (0=EX/MEM, 1=MEM/WB, 2=post-WB); legal range 2..8.
REQ-002 SHALL have parameter NUM_SRC, default 2, number of source operands checked per cycle; legal range 1..4.
REQ-003 SHALL have parameter LOAD_LAT, default 1, lowest entry index from which load data is forwardable; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AW, default 5, register address width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 advance  in  1  pipeline enable; entries shift only when high.
REQ-008 flush  in  1  squash the instruction entering EX.
REQ-009 issue_valid  in  1  instruction entering EX is real (not a bubble).
REQ-010 issue_we  in  1  instruction writes issue_rd.
REQ-011 issue_is_load  in  1  instruction is a load (write data produced in MEM).
REQ-012 issue_is_store  in  1  instruction is a store.
REQ-013 issue_rd  in  AW  destination register.
REQ-014 issue_rt  in  AW  store-data register.
REQ-015 src_valid  in  NUM_SRC  per-operand "operand is read".
REQ-016 src_addr  in  NUM_SRC*AW  operand addresses, operand i at bits [i*AW +: AW].
REQ-017 fwd_sel  out  NUM_SRC*SW  per-operand select, SW=clog2(DEPTH+1); 0=register file, k+1=entry k.
REQ-018 stall  out  1  load-use hazard; hold instruction entering EX.
REQ-019 forwardM  out  1  forward MEM/WB load data to store data in MEM.
REQ-020 stall_count  out  16  saturating count of stalled cycles.
REQ-021 clear_stats  in  1  clears stall_count.

Function
REQ-022 Each entry SHALL hold {valid, we, is_load, is_store, rd, rt}.
REQ-023 On advance=1, entry k SHALL load entry k-1 for k=1..DEPTH-1; the oldest entry is discarded.
REQ-024 On advance=1, entry 0 SHALL load the issue fields when stall=0 and flush=0, otherwise a bubble (valid=0).
REQ-025 On advance=0, all entries SHALL hold, except that flush=1 SHALL clear entry 0 valid.
REQ-026 Operand i SHALL match entry k when src_valid[i], entry valid, entry we, rd==src_addr, and src_addr!=0.
REQ-027 fwd_sel[i] SHALL be k+1 for the lowest matching k (youngest wins), or 0 if there is no match; this output is combinational from state and src inputs.
REQ-028 stall SHALL be 1 when, for any operand, the youngest matching entry has is_load=1 and index < LOAD_LAT; fwd_sel for that operand is then don't-care.
REQ-029 stall SHALL be forced to 0 when issue_valid=0 or flush=1.
REQ-030 forwardM SHALL be 1 when entry 0 is a valid store, entry 1 is a valid load with we=1, entry1.rd==entry0.rt, and rt!=0.
REQ-031 stall_count SHALL increment on each cycle with stall=1 and advance=1, saturate at 16'hFFFF, and clear on clear_stats (clear wins over increment).

Reset
REQ-032 reset=1 SHALL clear every entry valid bit and stall_count at the next edge, overriding advance, flush and clear_stats.
REQ-033 Once reset completes, fwd_sel SHALL be all 0 and stall and forwardM SHALL be 0 until the first valid issue advances.

Structure
REQ-034 Shared package: the entry record typedef, SW derivation, and the fwd_sel encoding constants (SEL_RF=0).
REQ-035 One sub-module, fwd_match, SHALL perform the per-operand priority match (one instance per operand).

Verification
REQ-036 Load r1 issued, next instruction reads r1 with advance=1 -> stall=1 for one cycle, bubble in entry 0; the following cycle fwd_sel=2, stall=0, stall_count=1.
REQ-037 ALU writes r3 at entry 0 and entry 1 (two writers), operand reads r3 -> fwd_sel=1 (youngest).
REQ-038 Operand reads r0 while an entry writes r0 -> fwd_sel=0, stall=0.
REQ-039 Load r5 in entry 1, store with rt=5 in entry 0 -> forwardM=1; store rt=6 -> forwardM=0.
REQ-040 Hazard with flush=1 -> stall=0 and entry 0 bubble; with advance=0, entries unchanged across 3 cycles.
REQ-041 stall_count preset to 16'hFFFF plus a further stall -> holds 16'hFFFF; reset mid-stall -> all outputs 0 at the next cycle.
